// File: rtl/cpu_pkg.sv
// Shared CPU datapath widths and the writeback queue entry layout.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fwd_lookup.sv
// Forwarding lookup over age-ordered entries (index 0 oldest); youngest match wins.
// Purely combinational; address 0 never hits.
module wb_fwd_lookup
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wb_entry_t             entries [DEPTH],
    input  logic [DEPTH-1:0]      valid,
    input  logic [REG_ADDR_W-1:0] addr,
    output logic                  hit,
    output logic [DATA_W-1:0]     data
);

    always_comb begin
        hit  = 1'b0;
        data = '0;
        // Later (younger) matches overwrite earlier ones.
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (addr != '0) && (entries[i].dest == addr)) begin
                hit  = 1'b1;
                data = entries[i].data;
            end
        end
    end

endmodule

// File: rtl/reg_writeback_queue.sv
// In-order register writeback FIFO; new entry reaches the write port 1 cycle after enqueue.
// wbReady = !full stalls producers; write port holds while wbAck=0. WB_FORWARD_EN adds pending-value forwarding.
module reg_writeback_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wbValid,
    output logic                  wbReady,
    input  logic [REG_ADDR_W-1:0] wbDest,
    input  logic [DATA_W-1:0]     aluResult,
    input  logic [DATA_W-1:0]     memData,
    input  logic                  MemtoReg,
    output logic [REG_ADDR_W-1:0] regW,
    output logic [DATA_W-1:0]     wRegData,
    output logic                  RegWrite,
    input  logic                  wbAck,
    input  logic [REG_ADDR_W-1:0] reg1,
    input  logic [REG_ADDR_W-1:0] reg2,
    output logic                  fwd1Hit,
    output logic                  fwd2Hit,
    output logic [DATA_W-1:0]     fwd1Data,
    output logic [DATA_W-1:0]     fwd2Data,
    output logic [PTR_W:0]        count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             wr_vld_q, wr_vld_d;
    wb_entry_t        wr_q, wr_d;
    wb_entry_t        in_entry;
    logic             enq;
    logic             deq;

    assign wbReady  = (count_q != FULL_CNT);
    assign in_entry = '{dest: wbDest, data: (MemtoReg ? memData : aluResult)};
    // x0 results are acknowledged to the producer but never stored.
    assign enq      = wbValid && wbReady && (wbDest != '0);
    assign deq      = wr_vld_q && wbAck;

    always_comb begin
        head_d   = head_q + PTR_W'(deq);
        tail_d   = tail_q + PTR_W'(enq);
        count_d  = count_q + (PTR_W+1)'(enq) - (PTR_W+1)'(deq);
        wr_vld_d = (count_d != '0);
        wr_d     = '0;
        // Next head comes from storage if an older entry survives, else from the input.
        if (count_q > (PTR_W+1)'(deq)) begin
            wr_d = mem_q[head_d];
        end else if (enq) begin
            wr_d = in_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            wr_vld_q <= 1'b0;
            wr_q     <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            wr_vld_q <= wr_vld_d;
            wr_q     <= wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[tail_q] <= in_entry;
        end
    end

    assign regW     = wr_q.dest;
    assign wRegData = wr_q.data;
    assign RegWrite = wr_vld_q;
    assign count    = count_q;

`ifdef WB_FORWARD_EN
    wb_entry_t        age_ord [DEPTH];
    logic [DEPTH-1:0] age_vld;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_ord[i] = mem_q[head_q + PTR_W'(i)];
            age_vld[i] = ((PTR_W+1)'(i) < count_q);
        end
    end

    wb_fwd_lookup #(.DEPTH(DEPTH)) u_fwd1 (
        .entries (age_ord),
        .valid   (age_vld),
        .addr    (reg1),
        .hit     (fwd1Hit),
        .data    (fwd1Data)
    );

    wb_fwd_lookup #(.DEPTH(DEPTH)) u_fwd2 (
        .entries (age_ord),
        .valid   (age_vld),
        .addr    (reg2),
        .hit     (fwd2Hit),
        .data    (fwd2Data)
    );
`else
    logic unused_fwd_addr;
    assign unused_fwd_addr = ^{reg1, reg2};
    assign fwd1Hit  = 1'b0;
    assign fwd2Hit  = 1'b0;
    assign fwd1Data = '0;
    assign fwd2Data = '0;
`endif

endmodule

// File: doc/reg_writeback_queue.md
Name: reg_writeback_queue

Overview:
- Writer side of the register-file write port (regW / wRegData / RegWrite).
- Accepts completed results from the execute/memory stage and selects ALU result or load data per entry.
- Buffers them in a small in-order FIFO and issues one register write per accepted handshake.
- Optionally forwards pending (not yet written) values to the reg1/reg2 read addresses so decode does not read stale data.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- PTR_W, 2, pointer width; log2(DEPTH).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high.
- wbValid  input  1  result offered this cycle.
- wbReady  output  1  queue can accept; combinational, equals !full.
- wbDest  input  5  destination register number.
- aluResult  input  32  ALU result.
- memData  input  32  load data.
- MemtoReg  input  1  1 selects memData, 0 selects aluResult; sampled at enqueue.
- regW  output  5  write address to the register file.
- wRegData  output  32  write data to the register file.
- RegWrite  output  1  write request.
- wbAck  input  1  register file accepted the write this cycle.
- reg1  input  5  forwarding lookup address, port 1.
- reg2  input  5  forwarding lookup address, port 2.
- fwd1Hit  output  1  pending write to reg1 exists.
- fwd2Hit  output  1  pending write to reg2 exists.
- fwd1Data  output  32  youngest pending value for reg1.
- fwd2Data  output  32  youngest pending value for reg2.
- count  output  PTR_W+1  current occupancy.

Behaviour:
- Reset (synchronous, active-high): head=0, tail=0, count=0, RegWrite=0, regW=0, wRegData=0, fwd*Hit=0, fwd*Data=0. Entry contents are don't-care. Reset mid-write drops all pending entries; RegWrite falls on the next edge.
- Enqueue:
  - Occurs when wbValid && wbReady.
  - Stores {wbDest, MemtoReg ? memData : aluResult} at tail; tail wraps modulo DEPTH.
  - wbDest==0 is accepted but discarded: no entry, no count change (x0 is never written).
- Issue:
  - regW, wRegData and RegWrite are driven from the head entry, registered.
  - RegWrite=1 whenever count!=0 after the edge. An entry enqueued into an empty queue appears on the write port 1 cycle later.
  - Dequeue on RegWrite && wbAck; head wraps modulo DEPTH.
  - While wbAck=0, RegWrite, regW and wRegData hold stable.
- Simultaneous enqueue and dequeue:
  - Allowed when not full; count unchanged, both pointers advance.
  - When full, wbReady=0 and there is no same-cycle pass-through, even if wbAck=1.
- Boundaries:
  - Full: count==DEPTH; further wbValid is stalled, not dropped.
  - Empty: RegWrite=0; wbAck is ignored.
- States are implied by count: EMPTY (0), PARTIAL, FULL (DEPTH).
- Ordering: strictly in order; two entries to the same register are written in arrival order.

Optional Feature:
- WB_FORWARD_EN defined:
  - fwd1Hit/fwd1Data and fwd2Hit/fwd2Data are combinational lookups over valid entries.
  - When several entries match, the youngest (closest to tail) wins.
  - reg==0 never hits.
  - The head entry counts as pending until dequeued.
- WB_FORWARD_EN undefined: fwd*Hit are tied 0, fwd*Data tied 0, no lookup logic.

Decomposition:
- Shared package (cpu_pkg) holds:
  - REG_ADDR_W=5, DATA_W=32.
  - The wb_entry_t struct {dest, data}.
- One natural sub-module: wb_fwd_lookup. It takes the entry array, a valid mask and an address, and returns hit and youngest data. It is instantiated twice, only under WB_FORWARD_EN.

Test Plan:
- Single ALU result: wbDest=3, aluResult=0x10, MemtoReg=0, wbAck=1 -> next cycle RegWrite=1, regW=3, wRegData=0x10; queue empty one cycle after ack.
- Load select and stall: wbDest=9, memData=0x04040404, MemtoReg=1, wbAck=0 for 3 cycles -> outputs held for all 3 cycles; write completes on the first wbAck=1.
- Fill to full: 4 enqueues to x1, x2, x19, x20 with wbAck=0 -> count=4, wbReady=0. A 5th wbValid to x25 stalls. Raise wbAck: writes issue in order x1, x2, x19, x20, x25.
- x0 discard: wbDest=0 with wbValid=1 -> count stays 0, RegWrite never asserts.
- Forwarding (WB_FORWARD_EN): enqueue x10=0x11 then x10=0x22, wbAck=0, reg1=10, reg2=0 -> fwd1Hit=1, fwd1Data=0x22, fwd2Hit=0.
- Reset mid-operation: 3 pending entries, assert reset one cycle -> RegWrite=0, count=0, no further writes.
